// File: rtl/ov7670_capture.sv
// OV7670 DVP capture: resynchronises the camera bus into clk_i and assembles RGB565 pixels behind a valid/ready output.
// Build option: define OV7670_CAPTURE_TEST_PATTERN_EN to replace camera bytes with a coordinate test pattern.
//
//  state    | meaning
//  WAIT_CFG | camera not configured yet
//  SYNC     | configured, waiting for vsync high to find a frame boundary
//  ARM      | vertical blanking, frame begins on vsync fall
//  FRAME    | capturing lines
module ov7670_capture (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_done_i,
  input  logic        cam_pclk_i,
  input  logic        cam_vsync_i,
  input  logic        cam_href_i,
  input  logic [7:0]  cam_data_i,
  input  logic        pix_ready_i,
  output logic        pix_valid_o,
  output logic [15:0] pix_data_o,
  output logic [9:0]  pix_x_o,
  output logic [8:0]  pix_y_o,
  output logic        frame_start_o,
  output logic        frame_end_o,
  output logic        drop_err_o
);

  localparam logic [1:0] ST_WAIT_CFG = 2'd0;
  localparam logic [1:0] ST_SYNC     = 2'd1;
  localparam logic [1:0] ST_ARM      = 2'd2;
  localparam logic [1:0] ST_FRAME    = 2'd3;
  localparam logic [9:0] X_MAX       = 10'd1023;
  localparam logic [8:0] Y_MAX       = 9'd511;

  logic        pclk_meta_q, pclk_sync_q, pclk_prev_q;
  logic        vsync_meta_q, vsync_sync_q, vsync_prev_q;
  logic        href_meta_q, href_sync_q, href_prev_q;
  logic [7:0]  data_meta_q, data_sync_q;
  logic [1:0]  state_q, state_d;
  logic        phase_q, phase_d;
  logic [7:0]  hi_byte_q, hi_byte_d;
  logic        valid_q, valid_d;
  logic [15:0] pix_q, pix_d;
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic        inc_x_q, inc_x_d;
  logic        line_end_q, line_end_d;
  logic        fs_q, fs_d, fe_q, fe_d, drop_q, drop_d;
  logic        pclk_rise, vsync_rise, vsync_fall, href_fall, byte_en;
  logic [15:0] new_pix;

  assign pclk_rise  = pclk_sync_q & ~pclk_prev_q;
  assign vsync_rise = vsync_sync_q & ~vsync_prev_q;
  assign vsync_fall = ~vsync_sync_q & vsync_prev_q;
  assign href_fall  = ~href_sync_q & href_prev_q;
  // href_prev keeps a byte that lands in the same cycle as the href fall
  assign byte_en    = pclk_rise & (href_sync_q | href_prev_q) & ~vsync_sync_q;

`ifdef OV7670_CAPTURE_TEST_PATTERN_EN
  assign new_pix = {x_q[7:3], y_q[7:2], x_q[7:3] ^ y_q[7:3]};
`else
  assign new_pix = {hi_byte_q, data_sync_q};
`endif

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    hi_byte_d  = hi_byte_q;
    valid_d    = valid_q;
    pix_d      = pix_q;
    x_d        = x_q;
    y_d        = y_q;
    inc_x_d    = 1'b0;
    line_end_d = 1'b0;
    fs_d       = 1'b0;
    fe_d       = 1'b0;
    drop_d     = drop_q;

    if (valid_q && pix_ready_i) valid_d = 1'b0;

    // Column/row updates lag their event by one clk so pix_x/pix_y still describe the pixel just presented.
    if (inc_x_q && (x_q != X_MAX)) x_d = x_q + 10'd1;
    if (line_end_q) begin
      x_d = '0;
      if (y_q != Y_MAX) y_d = y_q + 9'd1;
    end

    case (state_q)
      ST_WAIT_CFG: if (cfg_done_i) state_d = ST_SYNC;
      ST_SYNC:     if (vsync_sync_q) state_d = ST_ARM;
      ST_ARM: begin
        if (vsync_fall) begin
          state_d = ST_FRAME;
          fs_d    = 1'b1;
          phase_d = 1'b0;
          x_d     = '0;
          y_d     = '0;
        end
      end
      ST_FRAME: begin
        if (vsync_rise) begin
          state_d = ST_ARM;
          fe_d    = 1'b1;
        end else begin
          if (byte_en) begin
            if (!phase_q) begin
              hi_byte_d = data_sync_q;
              phase_d   = 1'b1;
            end else begin
              phase_d = 1'b0;
              inc_x_d = 1'b1;
              if (!valid_q || pix_ready_i) begin
                valid_d = 1'b1;
                pix_d   = new_pix;
              end else begin
                drop_d = 1'b1;
              end
            end
          end
          if (href_fall) begin
            phase_d    = 1'b0;
            line_end_d = 1'b1;
          end
        end
      end
      default: state_d = ST_WAIT_CFG;
    endcase

    if (!cfg_done_i) begin
      state_d = ST_WAIT_CFG;
      phase_d = 1'b0;
      fs_d    = 1'b0;
      fe_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pclk_meta_q  <= 1'b0;
      pclk_sync_q  <= 1'b0;
      pclk_prev_q  <= 1'b0;
      vsync_meta_q <= 1'b0;
      vsync_sync_q <= 1'b0;
      vsync_prev_q <= 1'b0;
      href_meta_q  <= 1'b0;
      href_sync_q  <= 1'b0;
      href_prev_q  <= 1'b0;
      data_meta_q  <= '0;
      data_sync_q  <= '0;
      state_q      <= ST_WAIT_CFG;
      phase_q      <= 1'b0;
      hi_byte_q    <= '0;
      valid_q      <= 1'b0;
      pix_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      inc_x_q      <= 1'b0;
      line_end_q   <= 1'b0;
      fs_q         <= 1'b0;
      fe_q         <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      pclk_meta_q  <= cam_pclk_i;
      pclk_sync_q  <= pclk_meta_q;
      pclk_prev_q  <= pclk_sync_q;
      vsync_meta_q <= cam_vsync_i;
      vsync_sync_q <= vsync_meta_q;
      vsync_prev_q <= vsync_sync_q;
      href_meta_q  <= cam_href_i;
      href_sync_q  <= href_meta_q;
      href_prev_q  <= href_sync_q;
      data_meta_q  <= cam_data_i;
      data_sync_q  <= data_meta_q;
      state_q      <= state_d;
      phase_q      <= phase_d;
      hi_byte_q    <= hi_byte_d;
      valid_q      <= valid_d;
      pix_q        <= pix_d;
      x_q          <= x_d;
      y_q          <= y_d;
      inc_x_q      <= inc_x_d;
      line_end_q   <= line_end_d;
      fs_q         <= fs_d;
      fe_q         <= fe_d;
      drop_q       <= drop_d;
    end
  end

  assign pix_valid_o   = valid_q;
  assign pix_data_o    = pix_q;
  assign pix_x_o       = x_q;
  assign pix_y_o       = y_q;
  assign frame_start_o = fs_q;
  assign frame_end_o   = fe_q;
  assign drop_err_o    = drop_q;

endmodule

// File: doc/ov7670_capture.md
OV7670_CAPTURE -- requirements
Module: ov7670_capture

Interface
REQ-001 clk  input  1  system clock; clk frequency SHALL be at least 4x cam_pclk frequency.
REQ-002 rst  input  1  synchronous reset, active-high, sampled on rising clk.
REQ-003 cfg_done  input  1  SCCB configuration complete, from camera config block.
REQ-004 cam_pclk  input  1  camera pixel clock, asynchronous to clk.
REQ-005 cam_vsync  input  1  camera frame sync, high during vertical blanking.
REQ-006 cam_href  input  1  camera line-valid.
REQ-007 cam_data  input  8  camera byte bus.
REQ-008 pix_ready  input  1  downstream accepts pixel.
REQ-009 pix_valid  output  1  pix_data, pix_x and pix_y are valid.
REQ-010 pix_data  output  16  RGB565 pixel.
REQ-011 pix_x  output  10  column of pixel.
REQ-012 pix_y  output  9  row of pixel.
REQ-013 frame_start  output  1  one-clk pulse at frame begin.
REQ-014 frame_end  output  1  one-clk pulse at frame end.
REQ-015 drop_err  output  1  sticky flag: a pixel was lost.

Function
REQ-016 cam_pclk, cam_vsync, cam_href and cam_data SHALL each pass through a 2-flop synchronizer; a pclk rising edge SHALL be detected when the synchronized pclk is 1 and its previous value was 0.
REQ-017 The FSM SHALL have states WAIT_CFG, SYNC, ARM and FRAME.
REQ-018 WAIT_CFG->SYNC when cfg_done=1; SYNC->ARM when sync vsync=1; ARM->FRAME on a sync vsync falling edge; FRAME->ARM on a sync vsync rising edge.
REQ-019 frame_start SHALL pulse in the cycle FRAME is entered; frame_end SHALL pulse in the cycle FRAME is left via vsync.
REQ-020 cfg_done=0 in any state SHALL force WAIT_CFG next cycle with no frame_end pulse, and SHALL discard any partial byte.
REQ-021 In FRAME, for each pclk edge with sync href=1, bytes SHALL alternate: first byte to pix_data[15:8], second byte to pix_data[7:0].
REQ-022 pix_valid SHALL assert in the clk cycle after the clk in which the second byte's pclk edge is detected.
REQ-023 pix_valid SHALL hold, with data stable, until pix_valid && pix_ready; it SHALL then drop the next cycle unless a new pixel is completing in that cycle.
REQ-024 If a new pixel completes while pix_valid=1 and pix_ready=0, the new pixel SHALL be discarded, the held pixel kept, and drop_err set; pix_x SHALL still advance.
REQ-025 pix_x SHALL reset to 0 at line start, increment after each completed pixel, and saturate at 1023.
REQ-026 On a sync href falling edge, pix_x SHALL clear, pix_y SHALL increment (saturating at 511), and the byte phase SHALL reset to first byte; an odd trailing byte SHALL be discarded.
REQ-027 pix_y SHALL clear at frame_start.
REQ-028 A pclk edge and an href falling edge in the same cycle SHALL take the byte first, then apply the line end.
REQ-029 Bytes while vsync=1 or outside FRAME SHALL be ignored.

Reset
REQ-030 rst=1 SHALL set: state WAIT_CFG; pix_valid, frame_start, frame_end and drop_err 0; pix_data 0; pix_x 0; pix_y 0; byte phase first; synchronizers 0.
REQ-031 rst mid-frame SHALL abandon the pixel in flight, with no frame_end pulse.
REQ-032 Only rst SHALL clear drop_err.

Configuration
REQ-033 With macro OV7670_CAPTURE_TEST_PATTERN_EN defined, pix_data SHALL be {pix_x[7:3], pix_y[7:2], pix_x[7:3]^pix_y[7:3]}, using the pix_x/pix_y of the completed pixel. cam_data is ignored; timing, FSM and handshake are unchanged.
REQ-034 Without OV7670_CAPTURE_TEST_PATTERN_EN, pix_data SHALL come from cam_data as in REQ-021.

Verification
REQ-035 cfg_done=0, full frame driven -> no pix_valid, no frame_start.
REQ-036 cfg_done=1; vsync high then low; one line of 4 bytes 0xF8,0x00,0x07,0xE0; pix_ready=1 -> frame_start once; pixels 0xF800 at x=0 and 0x07E0 at x=1, both y=0; each pix_valid one clk wide.
REQ-037 Two lines of 640 pixels, then vsync rise -> 1280 handshakes, last pixel at x=639 y=1, frame_end once.
REQ-038 pix_ready=0 held across 2 completed pixels -> first pixel held stable, drop_err=1, pix_x=2 after the second.
REQ-039 3 bytes in a line, then href falls -> 1 pixel emitted, pix_y=1, next line starts at x=0 with first-byte phase.
REQ-040 rst asserted mid-line -> next cycle all outputs at reset values; recovery requires cfg_done plus a new vsync cycle.
